// File: rtl/id_stage_pipe.sv
// Registered instruction-decode stage: instruction FIFO, head decode with operand
// forwarding and load-use hazard detection, valid/ready issue register to EX.
module id_stage_pipe #(
  parameter int unsigned ADDR_WIDTH     = 30,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned IBUF_DEPTH     = 2,
  parameter int unsigned FWD_STAGES     = 2,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned ALU_OP_BUS     = 4,
  parameter int unsigned MEM_OP_BUS     = 2,
  parameter int unsigned CTRL_OP_BUS    = 2,
  parameter int unsigned ISA_EXP_BUS    = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 if_valid_i,
  output logic                                 if_ready_o,
  input  logic [ADDR_WIDTH-1:0]                if_pc_i,
  input  logic [DATA_WIDTH-1:0]                if_insn_i,
  output logic [REG_ADDR_WIDTH-1:0]            gpr_rd_addr_0_o,
  output logic [REG_ADDR_WIDTH-1:0]            gpr_rd_addr_1_o,
  input  logic [DATA_WIDTH-1:0]                gpr_rd_data_0_i,
  input  logic [DATA_WIDTH-1:0]                gpr_rd_data_1_i,
  input  logic [FWD_STAGES-1:0]                fwd_en_i,
  input  logic [FWD_STAGES*REG_ADDR_WIDTH-1:0] fwd_addr_i,
  input  logic [FWD_STAGES*DATA_WIDTH-1:0]     fwd_data_i,
  input  logic                                 exe_mode_i,
  output logic [REG_ADDR_WIDTH-1:0]            creg_rd_addr_o,
  input  logic [DATA_WIDTH-1:0]                creg_rd_data_i,
  input  logic                                 flush_i,
  input  logic                                 ex_ready_i,
  output logic                                 id_valid_o,
  output logic [ADDR_WIDTH-1:0]                id_pc_o,
  output logic [ALU_OP_BUS-1:0]                alu_op_o,
  output logic [DATA_WIDTH-1:0]                alu_in_0_o,
  output logic [DATA_WIDTH-1:0]                alu_in_1_o,
  output logic [MEM_OP_BUS-1:0]                mem_op_o,
  output logic [DATA_WIDTH-1:0]                mem_wr_data_o,
  output logic [CTRL_OP_BUS-1:0]               ctrl_op_o,
  output logic [REG_ADDR_WIDTH-1:0]            dst_addr_o,
  output logic                                 gpr_wre_o,
  output logic [ISA_EXP_BUS-1:0]               exp_code_o,
  output logic [ADDR_WIDTH-1:0]                br_addr_o,
  output logic                                 br_taken_o,
  output logic                                 br_flag_o,
  output logic [CNT_WIDTH-1:0]                 ld_stall_cnt_o
);

  localparam int unsigned PTR_W = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;

  typedef enum logic [5:0] {
    OP_ANDR  = 6'h00, OP_ANDI  = 6'h01, OP_ORR   = 6'h02, OP_ORI   = 6'h03,
    OP_XORR  = 6'h04, OP_XORI  = 6'h05, OP_ADDSR = 6'h06, OP_ADDSI = 6'h07,
    OP_ADDUR = 6'h08, OP_ADDUI = 6'h09, OP_SUBSR = 6'h0a, OP_SUBUR = 6'h0b,
    OP_SHRLR = 6'h0c, OP_SHRLI = 6'h0d, OP_SHLLR = 6'h0e, OP_SHLLI = 6'h0f,
    OP_BE    = 6'h10, OP_BNE   = 6'h11, OP_BSGT  = 6'h12, OP_BUGT  = 6'h13,
    OP_JMP   = 6'h14, OP_CALL  = 6'h15, OP_LDW   = 6'h16, OP_STW   = 6'h17,
    OP_TRAP  = 6'h18, OP_RDCR  = 6'h19, OP_WRCR  = 6'h1a, OP_EXRT  = 6'h1b
  } isa_op_e;

  localparam logic [ALU_OP_BUS-1:0]  ALU_NOP  = ALU_OP_BUS'(0), ALU_AND  = ALU_OP_BUS'(1),
                                     ALU_OR   = ALU_OP_BUS'(2), ALU_XOR  = ALU_OP_BUS'(3),
                                     ALU_ADDS = ALU_OP_BUS'(4), ALU_ADDU = ALU_OP_BUS'(5),
                                     ALU_SUBS = ALU_OP_BUS'(6), ALU_SUBU = ALU_OP_BUS'(7),
                                     ALU_SHRL = ALU_OP_BUS'(8), ALU_SHLL = ALU_OP_BUS'(9);
  localparam logic [MEM_OP_BUS-1:0]  MEM_NOP = MEM_OP_BUS'(0), MEM_LDW = MEM_OP_BUS'(1),
                                     MEM_STW = MEM_OP_BUS'(2);
  localparam logic [CTRL_OP_BUS-1:0] CTRL_NOP  = CTRL_OP_BUS'(0), CTRL_RDCR = CTRL_OP_BUS'(1),
                                     CTRL_WRCR = CTRL_OP_BUS'(2), CTRL_EXRT = CTRL_OP_BUS'(3);
  localparam logic [ISA_EXP_BUS-1:0] EXP_NO_EXP  = ISA_EXP_BUS'(0), EXP_UNDEF = ISA_EXP_BUS'(2),
                                     EXP_TRAP    = ISA_EXP_BUS'(5), EXP_PRV_VIO = ISA_EXP_BUS'(6);
  localparam logic                   CPU_KERNEL_MODE = 1'b0;

  logic [ADDR_WIDTH-1:0] fifo_pc   [IBUF_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_insn [IBUF_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [PTR_W:0]        count;
  logic                  full, head_valid, hazard, issue, br_clear, push;

  logic [ADDR_WIDTH-1:0]     head_pc;
  logic [DATA_WIDTH-1:0]     head_insn, ra_data, rb_data, imm_s, imm_u;
  logic [5:0]                opcode;
  logic [REG_ADDR_WIDTH-1:0] ra, rb, rc;
  logic [ALU_OP_BUS-1:0]     d_alu_op;
  logic [DATA_WIDTH-1:0]     d_alu_in_0, d_alu_in_1, d_mem_wr_data;
  logic [MEM_OP_BUS-1:0]     d_mem_op;
  logic [CTRL_OP_BUS-1:0]    d_ctrl_op;
  logic [REG_ADDR_WIDTH-1:0] d_dst;
  logic                      d_wre, d_br_taken, d_br_flag;
  logic [ISA_EXP_BUS-1:0]    d_exp;
  logic [ADDR_WIDTH-1:0]     d_br_addr;

  assign full       = (count == (PTR_W+1)'(IBUF_DEPTH));
  assign head_valid = (count != '0);
  assign if_ready_o = !full;
  assign head_pc    = fifo_pc[rd_ptr];
  assign head_insn  = fifo_insn[rd_ptr];

  assign opcode = head_insn[31:26];
  assign ra     = head_insn[25:21];
  assign rb     = head_insn[20:16];
  assign rc     = head_insn[15:11];
  assign imm_s  = {{(DATA_WIDTH-16){head_insn[15]}}, head_insn[15:0]};
  assign imm_u  = {{(DATA_WIDTH-16){1'b0}}, head_insn[15:0]};

  assign gpr_rd_addr_0_o = ra;
  assign gpr_rd_addr_1_o = rb;
  assign creg_rd_addr_o  = ra;

  // Lowest-index matching stage wins, so the first hit stops further selection.
  always_comb begin
    logic hit_a, hit_b;
    ra_data = gpr_rd_data_0_i;
    rb_data = gpr_rd_data_1_i;
    hit_a   = 1'b0;
    hit_b   = 1'b0;
    for (int unsigned k = 0; k < FWD_STAGES; k++) begin
      if (!hit_a && fwd_en_i[k] && fwd_addr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == ra) begin
        ra_data = fwd_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        hit_a   = 1'b1;
      end
      if (!hit_b && fwd_en_i[k] && fwd_addr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == rb) begin
        rb_data = fwd_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        hit_b   = 1'b1;
      end
    end
  end

  always_comb begin
    d_alu_op      = ALU_NOP;
    d_alu_in_0    = ra_data;
    d_alu_in_1    = rb_data;
    d_mem_op      = MEM_NOP;
    d_mem_wr_data = rb_data;
    d_ctrl_op     = CTRL_NOP;
    d_dst         = rc;
    d_wre         = 1'b0;
    d_exp         = EXP_NO_EXP;
    d_br_addr     = '0;
    d_br_taken    = 1'b0;
    d_br_flag     = 1'b0;
    case (opcode)
      OP_ANDR:  begin d_alu_op = ALU_AND;  d_wre = 1'b1; end
      OP_ANDI:  begin d_alu_op = ALU_AND;  d_alu_in_1 = imm_u; d_dst = rb; d_wre = 1'b1; end
      OP_ORR:   begin d_alu_op = ALU_OR;   d_wre = 1'b1; end
      OP_ORI:   begin d_alu_op = ALU_OR;   d_alu_in_1 = imm_u; d_dst = rb; d_wre = 1'b1; end
      OP_XORR:  begin d_alu_op = ALU_XOR;  d_wre = 1'b1; end
      OP_XORI:  begin d_alu_op = ALU_XOR;  d_alu_in_1 = imm_u; d_dst = rb; d_wre = 1'b1; end
      OP_ADDSR: begin d_alu_op = ALU_ADDS; d_wre = 1'b1; end
      OP_ADDSI: begin d_alu_op = ALU_ADDS; d_alu_in_1 = imm_s; d_dst = rb; d_wre = 1'b1; end
      OP_ADDUR: begin d_alu_op = ALU_ADDU; d_wre = 1'b1; end
      OP_ADDUI: begin d_alu_op = ALU_ADDU; d_alu_in_1 = imm_s; d_dst = rb; d_wre = 1'b1; end
      OP_SUBSR: begin d_alu_op = ALU_SUBS; d_wre = 1'b1; end
      OP_SUBUR: begin d_alu_op = ALU_SUBU; d_wre = 1'b1; end
      OP_SHRLR: begin d_alu_op = ALU_SHRL; d_wre = 1'b1; end
      OP_SHRLI: begin d_alu_op = ALU_SHRL; d_alu_in_1 = imm_u; d_dst = rb; d_wre = 1'b1; end
      OP_SHLLR: begin d_alu_op = ALU_SHLL; d_wre = 1'b1; end
      OP_SHLLI: begin d_alu_op = ALU_SHLL; d_alu_in_1 = imm_u; d_dst = rb; d_wre = 1'b1; end
      OP_BE:    begin d_br_addr = head_pc + imm_s[ADDR_WIDTH-1:0]; d_br_flag = 1'b1;
                      d_br_taken = (ra_data == rb_data); end
      OP_BNE:   begin d_br_addr = head_pc + imm_s[ADDR_WIDTH-1:0]; d_br_flag = 1'b1;
                      d_br_taken = (ra_data != rb_data); end
      OP_BSGT:  begin d_br_addr = head_pc + imm_s[ADDR_WIDTH-1:0]; d_br_flag = 1'b1;
                      d_br_taken = ($signed(ra_data) < $signed(rb_data)); end
      OP_BUGT:  begin d_br_addr = head_pc + imm_s[ADDR_WIDTH-1:0]; d_br_flag = 1'b1;
                      d_br_taken = (ra_data < rb_data); end
      OP_JMP:   begin d_br_addr = ra_data[ADDR_WIDTH+1:2]; d_br_taken = 1'b1; d_br_flag = 1'b1; end
      OP_CALL:  begin
        d_br_addr  = ra_data[ADDR_WIDTH+1:2];
        d_br_taken = 1'b1;
        d_br_flag  = 1'b1;
        d_alu_in_0 = DATA_WIDTH'({head_pc + ADDR_WIDTH'(1), 2'b00});
        d_dst      = REG_ADDR_WIDTH'(31);
        d_wre      = 1'b1;
      end
      OP_LDW:   begin d_alu_op = ALU_ADDU; d_alu_in_1 = imm_s; d_mem_op = MEM_LDW;
                      d_dst = rb; d_wre = 1'b1; end
      OP_STW:   begin d_alu_op = ALU_ADDU; d_alu_in_1 = imm_s; d_mem_op = MEM_STW; end
      OP_TRAP:  d_exp = EXP_TRAP;
      OP_RDCR:  if (exe_mode_i == CPU_KERNEL_MODE) begin
                  d_alu_in_0 = creg_rd_data_i; d_ctrl_op = CTRL_RDCR; d_dst = rb; d_wre = 1'b1;
                end else d_exp = EXP_PRV_VIO;
      OP_WRCR:  if (exe_mode_i == CPU_KERNEL_MODE) d_ctrl_op = CTRL_WRCR;
                else d_exp = EXP_PRV_VIO;
      OP_EXRT:  if (exe_mode_i == CPU_KERNEL_MODE) d_ctrl_op = CTRL_EXRT;
                else d_exp = EXP_PRV_VIO;
      default:  d_exp = EXP_UNDEF;
    endcase
  end

  assign hazard   = id_valid_o && (mem_op_o == MEM_LDW) && (dst_addr_o == ra || dst_addr_o == rb);
  assign issue    = head_valid && !hazard && !flush_i && (!id_valid_o || ex_ready_i);
  assign br_clear = issue && d_br_taken;
  assign push     = if_valid_i && !full && !flush_i && !br_clear;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= if_pc_i;
      fifo_insn[wr_ptr] <= if_insn_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i || br_clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (issue) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, issue})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_o     <= 1'b0;
      id_pc_o        <= '0;
      alu_op_o       <= ALU_NOP;
      alu_in_0_o     <= '0;
      alu_in_1_o     <= '0;
      mem_op_o       <= MEM_NOP;
      mem_wr_data_o  <= '0;
      ctrl_op_o      <= CTRL_NOP;
      dst_addr_o     <= '0;
      gpr_wre_o      <= 1'b0;
      exp_code_o     <= EXP_NO_EXP;
      br_addr_o      <= '0;
      br_taken_o     <= 1'b0;
      br_flag_o      <= 1'b0;
      ld_stall_cnt_o <= '0;
    end else begin
      if (flush_i) begin
        id_valid_o <= 1'b0;
      end else if (issue) begin
        id_valid_o    <= 1'b1;
        id_pc_o       <= head_pc;
        alu_op_o      <= d_alu_op;
        alu_in_0_o    <= d_alu_in_0;
        alu_in_1_o    <= d_alu_in_1;
        mem_op_o      <= d_mem_op;
        mem_wr_data_o <= d_mem_wr_data;
        ctrl_op_o     <= d_ctrl_op;
        dst_addr_o    <= d_dst;
        gpr_wre_o     <= d_wre;
        exp_code_o    <= d_exp;
        br_addr_o     <= d_br_addr;
        br_taken_o    <= d_br_taken;
        br_flag_o     <= d_br_flag;
      end else if (ex_ready_i) begin
        id_valid_o <= 1'b0;
      end
      if (head_valid && hazard && !flush_i && ld_stall_cnt_o != '1)
        ld_stall_cnt_o <= ld_stall_cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: hand-computed expectations per scenario.
module tb_id_stage_pipe;

  localparam logic [5:0] OP_ANDR = 6'h00, OP_ADDSR = 6'h06, OP_ADDUR = 6'h08, OP_ADDUI = 6'h09,
                         OP_BE = 6'h10, OP_BNE = 6'h11, OP_CALL = 6'h15, OP_LDW = 6'h16,
                         OP_RDCR = 6'h19, OP_UNDEF = 6'h3f;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        if_valid_i = 1'b0, if_ready_o;
  logic [29:0] if_pc_i = '0;
  logic [31:0] if_insn_i = '0;
  logic [4:0]  gpr_rd_addr_0_o, gpr_rd_addr_1_o, creg_rd_addr_o, dst_addr_o;
  logic [31:0] gpr_rd_data_0_i, gpr_rd_data_1_i, creg_rd_data_i = '0;
  logic [1:0]  fwd_en_i = '0;
  logic [9:0]  fwd_addr_i = '0;
  logic [63:0] fwd_data_i = '0;
  logic        exe_mode_i = 1'b0, flush_i = 1'b0, ex_ready_i = 1'b1;
  logic        id_valid_o, gpr_wre_o, br_taken_o, br_flag_o;
  logic [29:0] id_pc_o, br_addr_o;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_in_0_o, alu_in_1_o, mem_wr_data_o;
  logic [1:0]  mem_op_o, ctrl_op_o;
  logic [2:0]  exp_code_o;
  logic [15:0] ld_stall_cnt_o;

  logic [31:0] regs [32];
  int total = 0, bad = 0;

  assign gpr_rd_data_0_i = regs[gpr_rd_addr_0_o];
  assign gpr_rd_data_1_i = regs[gpr_rd_addr_1_o];

  id_stage_pipe #(.ADDR_WIDTH(30), .DATA_WIDTH(32), .IBUF_DEPTH(2), .FWD_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
    .if_pc_i(if_pc_i), .if_insn_i(if_insn_i),
    .gpr_rd_addr_0_o(gpr_rd_addr_0_o), .gpr_rd_addr_1_o(gpr_rd_addr_1_o),
    .gpr_rd_data_0_i(gpr_rd_data_0_i), .gpr_rd_data_1_i(gpr_rd_data_1_i),
    .fwd_en_i(fwd_en_i), .fwd_addr_i(fwd_addr_i), .fwd_data_i(fwd_data_i),
    .exe_mode_i(exe_mode_i), .creg_rd_addr_o(creg_rd_addr_o), .creg_rd_data_i(creg_rd_data_i),
    .flush_i(flush_i), .ex_ready_i(ex_ready_i), .id_valid_o(id_valid_o), .id_pc_o(id_pc_o),
    .alu_op_o(alu_op_o), .alu_in_0_o(alu_in_0_o), .alu_in_1_o(alu_in_1_o),
    .mem_op_o(mem_op_o), .mem_wr_data_o(mem_wr_data_o), .ctrl_op_o(ctrl_op_o),
    .dst_addr_o(dst_addr_o), .gpr_wre_o(gpr_wre_o), .exp_code_o(exp_code_o),
    .br_addr_o(br_addr_o), .br_taken_o(br_taken_o), .br_flag_o(br_flag_o),
    .ld_stall_cnt_o(ld_stall_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] r_ins(input logic [5:0] op, input logic [4:0] a, b, c);
    return {op, a, b, c, 11'd0};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] a, b, input logic [15:0] imm);
    return {op, a, b, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [29:0] pc, input logic [31:0] insn);
    if_valid_i = 1'b1;
    if_pc_i    = pc;
    if_insn_i  = insn;
    step();
    if_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    if_valid_i = 1'b0; ex_ready_i = 1'b1; flush_i = 1'b0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", id_valid_o); end
    total++; if (if_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0h exp=1", if_ready_o); end
    total++; if (exp_code_o !== 3'd0) begin bad++; $display("FAIL rst_exp got=%0h exp=0", exp_code_o); end
    total++; if (ld_stall_cnt_o !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0h exp=0", ld_stall_cnt_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_addsr();
    idle(1);
    push(30'h10, r_ins(OP_ADDSR, 5'd1, 5'd2, 5'd3));
    total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL add_latency got=%0h exp=0", id_valid_o); end
    step();
    total++; if (id_valid_o !== 1'b1) begin bad++; $display("FAIL add_valid got=%0h exp=1", id_valid_o); end
    total++; if (alu_op_o !== 4'd4) begin bad++; $display("FAIL add_op got=%0h exp=4", alu_op_o); end
    total++; if (alu_in_0_o !== 32'd5) begin bad++; $display("FAIL add_in0 got=%0h exp=5", alu_in_0_o); end
    total++; if (alu_in_1_o !== 32'hFFFF_FFF9) begin bad++; $display("FAIL add_in1 got=%0h exp=fffffff9", alu_in_1_o); end
    total++; if (dst_addr_o !== 5'd3 || gpr_wre_o !== 1'b1) begin bad++; $display("FAIL add_dst got=%0h/%0h exp=3/1", dst_addr_o, gpr_wre_o); end
    total++; if (id_pc_o !== 30'h10) begin bad++; $display("FAIL add_pc got=%0h exp=10", id_pc_o); end
    step();
    total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL add_bubble got=%0h exp=0", id_valid_o); end
  endtask

  task automatic test_load_use();
    idle(1);
    push(30'h20, i_ins(OP_LDW, 5'd0, 5'd4, 16'h0008));
    push(30'h21, r_ins(OP_ANDR, 5'd4, 5'd5, 5'd6));
    total++; if (mem_op_o !== 2'd1 || dst_addr_o !== 5'd4 || alu_in_1_o !== 32'd8) begin bad++;
      $display("FAIL ldw_issue got=%0h/%0h/%0h exp=1/4/8", mem_op_o, dst_addr_o, alu_in_1_o); end
    step();
    total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL ldu_bubble got=%0h exp=0", id_valid_o); end
    total++; if (ld_stall_cnt_o !== 16'd1) begin bad++; $display("FAIL ldu_cnt got=%0h exp=1", ld_stall_cnt_o); end
    step();
    total++; if (id_valid_o !== 1'b1 || id_pc_o !== 30'h21 || alu_op_o !== 4'd1) begin bad++;
      $display("FAIL ldu_andr got=%0h/%0h/%0h exp=1/21/1", id_valid_o, id_pc_o, alu_op_o); end
    total++; if (alu_in_0_o !== 32'hFF || alu_in_1_o !== 32'h0F0F || dst_addr_o !== 5'd6) begin bad++;
      $display("FAIL ldu_opnd got=%0h/%0h/%0h exp=ff/f0f/6", alu_in_0_o, alu_in_1_o, dst_addr_o); end
    total++; if (ld_stall_cnt_o !== 16'd1) begin bad++; $display("FAIL ldu_cnt_hold got=%0h exp=1", ld_stall_cnt_o); end
  endtask

  task automatic test_forward();
    idle(2);
    fwd_en_i = 2'b11; fwd_addr_i = {5'd1, 5'd1}; fwd_data_i = {32'hB, 32'hA};
    push(30'h30, r_ins(OP_ADDUR, 5'd1, 5'd2, 5'd7));
    step();
    total++; if (alu_in_0_o !== 32'hA) begin bad++; $display("FAIL fwd_prio got=%0h exp=a", alu_in_0_o); end
    total++; if (alu_in_1_o !== 32'hFFFF_FFF9) begin bad++; $display("FAIL fwd_rf_rb got=%0h exp=fffffff9", alu_in_1_o); end
    fwd_en_i = 2'b10; fwd_addr_i = {5'd2, 5'd1};
    push(30'h31, r_ins(OP_ADDUR, 5'd1, 5'd2, 5'd7));
    step();
    total++; if (alu_in_0_o !== 32'd5 || alu_in_1_o !== 32'hB) begin bad++;
      $display("FAIL fwd_stage1 got=%0h/%0h exp=5/b", alu_in_0_o, alu_in_1_o); end
    fwd_en_i = '0;
  endtask

  task automatic test_backpressure();
    idle(2);
    ex_ready_i = 1'b0;
    push(30'h40, i_ins(OP_ADDUI, 5'd0, 5'd10, 16'd1));
    push(30'h41, i_ins(OP_ADDUI, 5'd0, 5'd10, 16'd2));
    push(30'h42, i_ins(OP_ADDUI, 5'd0, 5'd10, 16'd3));
    if_valid_i = 1'b1; if_pc_i = 30'h43; if_insn_i = i_ins(OP_ADDUI, 5'd0, 5'd10, 16'd4);
    for (int i = 0; i < 3; i++) begin
      total++; if (id_valid_o !== 1'b1 || id_pc_o !== 30'h40 || alu_in_1_o !== 32'd1 || if_ready_o !== 1'b0) begin bad++;
        $display("FAIL bp_hold got=%0h/%0h/%0h/%0h exp=1/40/1/0", id_valid_o, id_pc_o, alu_in_1_o, if_ready_o); end
      step();
    end
    if_valid_i = 1'b0; ex_ready_i = 1'b1;
    step();
    total++; if (id_pc_o !== 30'h41 || alu_in_1_o !== 32'd2) begin bad++; $display("FAIL bp_second got=%0h/%0h exp=41/2", id_pc_o, alu_in_1_o); end
    step();
    total++; if (id_pc_o !== 30'h42 || alu_in_1_o !== 32'd3) begin bad++; $display("FAIL bp_third got=%0h/%0h exp=42/3", id_pc_o, alu_in_1_o); end
    step();
    total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL bp_nomore got=%0h exp=0", id_valid_o); end
  endtask

  task automatic test_branch();
    idle(2);
    ex_ready_i = 1'b0;
    push(30'h3C, i_ins(OP_ADDUI, 5'd0, 5'd10, 16'd9));
    push(30'h50, i_ins(OP_BE, 5'd1, 5'd1, 16'd4));
    push(30'h51, i_ins(OP_ADDUI, 5'd0, 5'd10, 16'd7));
    ex_ready_i = 1'b1;
    step();
    total++; if (id_pc_o !== 30'h50 || br_taken_o !== 1'b1 || br_flag_o !== 1'b1 || br_addr_o !== 30'h54) begin bad++;
      $display("FAIL be_taken got=%0h/%0h/%0h/%0h exp=50/1/1/54", id_pc_o, br_taken_o, br_flag_o, br_addr_o); end
    total++; if (if_ready_o !== 1'b1) begin bad++; $display("FAIL be_fifo_clr got=%0h exp=1", if_ready_o); end
    step();
    total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL be_wrong_path got=%0h exp=0", id_valid_o); end
    push(30'h60, i_ins(OP_BE, 5'd1, 5'd1, 16'hFFFE));
    if_valid_i = 1'b1; if_pc_i = 30'h61; if_insn_i = i_ins(OP_ADDUI, 5'd0, 5'd10, 16'd5);
    step();
    if_valid_i = 1'b0;
    total++; if (br_taken_o !== 1'b1 || br_addr_o !== 30'h5E) begin bad++; $display("FAIL be_back got=%0h/%0h exp=1/5e", br_taken_o, br_addr_o); end
    step();
    total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL be_discard got=%0h exp=0", id_valid_o); end
    push(30'h70, i_ins(OP_BNE, 5'd1, 5'd1, 16'd8));
    step();
    total++; if (br_taken_o !== 1'b0 || br_flag_o !== 1'b1 || br_addr_o !== 30'h78) begin bad++;
      $display("FAIL bne_nt got=%0h/%0h/%0h exp=0/1/78", br_taken_o, br_flag_o, br_addr_o); end
    push(30'h50, i_ins(OP_CALL, 5'd8, 5'd0, 16'd0));
    step();
    total++; if (br_addr_o !== 30'h400 || alu_in_0_o !== 32'h144 || dst_addr_o !== 5'd31 || gpr_wre_o !== 1'b1) begin bad++;
      $display("FAIL call got=%0h/%0h/%0h/%0h exp=400/144/1f/1", br_addr_o, alu_in_0_o, dst_addr_o, gpr_wre_o); end
  endtask

  task automatic test_priv();
    idle(2);
    exe_mode_i = 1'b1; creg_rd_data_i = 32'h1234;
    push(30'h80, i_ins(OP_RDCR, 5'd2, 5'd3, 16'd0));
    total++; if (creg_rd_addr_o !== 5'd2) begin bad++; $display("FAIL creg_addr got=%0h exp=2", creg_rd_addr_o); end
    step();
    total++; if (exp_code_o !== 3'd6 || gpr_wre_o !== 1'b0 || ctrl_op_o !== 2'd0) begin bad++;
      $display("FAIL rdcr_user got=%0h/%0h/%0h exp=6/0/0", exp_code_o, gpr_wre_o, ctrl_op_o); end
    exe_mode_i = 1'b0;
    push(30'h81, i_ins(OP_RDCR, 5'd2, 5'd3, 16'd0));
    step();
    total++; if (exp_code_o !== 3'd0 || alu_in_0_o !== 32'h1234 || ctrl_op_o !== 2'd1 || dst_addr_o !== 5'd3 || gpr_wre_o !== 1'b1) begin bad++;
      $display("FAIL rdcr_kern got=%0h/%0h/%0h/%0h/%0h exp=0/1234/1/3/1", exp_code_o, alu_in_0_o, ctrl_op_o, dst_addr_o, gpr_wre_o); end
    push(30'h82, r_ins(OP_UNDEF, 5'd1, 5'd2, 5'd3));
    step();
    total++; if (exp_code_o !== 3'd2 || gpr_wre_o !== 1'b0) begin bad++;
      $display("FAIL undef got=%0h/%0h exp=2/0", exp_code_o, gpr_wre_o); end
  endtask

  task automatic test_flush();
    idle(2);
    ex_ready_i = 1'b0;
    push(30'h90, i_ins(OP_ADDUI, 5'd0, 5'd10, 16'd1));
    push(30'h91, i_ins(OP_ADDUI, 5'd0, 5'd10, 16'd2));
    push(30'h92, i_ins(OP_ADDUI, 5'd0, 5'd10, 16'd3));
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    total++; if (id_valid_o !== 1'b0 || if_ready_o !== 1'b1) begin bad++;
      $display("FAIL flush got=%0h/%0h exp=0/1", id_valid_o, if_ready_o); end
    ex_ready_i = 1'b1;
    repeat (2) step();
    total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL flush_empty got=%0h exp=0", id_valid_o); end
    total++; if (ld_stall_cnt_o !== 16'd1) begin bad++; $display("FAIL flush_cnt got=%0h exp=1", ld_stall_cnt_o); end
  endtask

  task automatic test_reset_mid();
    idle(2);
    ex_ready_i = 1'b0;
    push(30'hA0, i_ins(OP_ADDUI, 5'd0, 5'd10, 16'd1));
    push(30'hA1, i_ins(OP_ADDUI, 5'd0, 5'd10, 16'd2));
    rst_n = 1'b0;
    #1;
    total++; if (id_valid_o !== 1'b0 || if_ready_o !== 1'b1 || ld_stall_cnt_o !== 16'd0) begin bad++;
      $display("FAIL rstm_ctl got=%0h/%0h/%0h exp=0/1/0", id_valid_o, if_ready_o, ld_stall_cnt_o); end
    total++; if (id_pc_o !== 30'd0 || alu_in_1_o !== 32'd0 || dst_addr_o !== 5'd0 || gpr_wre_o !== 1'b0) begin bad++;
      $display("FAIL rstm_data got=%0h/%0h/%0h/%0h exp=0/0/0/0", id_pc_o, alu_in_1_o, dst_addr_o, gpr_wre_o); end
    #3 rst_n = 1'b1;
    ex_ready_i = 1'b1;
    repeat (2) step();
    total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL rstm_empty got=%0h exp=0", id_valid_o); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
    regs[1] = 32'd5; regs[2] = 32'hFFFF_FFF9; regs[4] = 32'hFF; regs[5] = 32'h0F0F; regs[8] = 32'h1000;
    test_reset();
    test_addsr();
    test_load_use();
    test_forward();
    test_backpressure();
    test_branch();
    test_priv();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
